// File: rtl/aes_key_expand_ctrl_if.sv
// Key-schedule bus: key load/status, the shared SubWord port pair and the round-key read port.
// slave is the schedule controller; master is its client (sequencer + SubWord unit).
interface aes_key_expand_ctrl_if #(
    parameter int RK_W = 128
);
    logic            start;
    logic [RK_W-1:0] key_in;
    logic [31:0]     sub_word_o;
    logic [31:0]     sub_word_i;
    logic            busy;
    logic            keys_valid;
    logic [3:0]      rk_idx;
    logic            rk_rd;
    logic [RK_W-1:0] rk_out;
    logic            rk_out_valid;

    modport slave (
        input  start, key_in, sub_word_i, rk_idx, rk_rd,
        output sub_word_o, busy, keys_valid, rk_out, rk_out_valid
    );

    modport master (
        output start, key_in, sub_word_i, rk_idx, rk_rd,
        input  sub_word_o, busy, keys_valid, rk_out, rk_out_valid
    );
endinterface

// File: rtl/aes_key_expand_ctrl.sv
// Iterative AES-128 key expansion, one word w[i] per clock into an 11-entry round-key store.
// Latency: start edge N -> keys_valid after edge N+41; read port is one cycle; no backpressure.
module aes_key_expand_ctrl #(
    parameter int NR   = 10,
    parameter int RK_W = 128
) (
    input  logic                 clk,
    input  logic                 rst_n,
    aes_key_expand_ctrl_if.slave bus
);
    generate
        if (NR != 10 || RK_W != 128) begin : g_bad_cfg
            $error("aes_key_expand_ctrl supports only AES-128 (NR=10, RK_W=128)");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, EXPAND, DONE} state_t;

    state_t state, state_nxt;
    logic load, step;

    // Word slot 0 of each round key sits in bits [127:96], i.e. packed index 3.
    logic [3:0][31:0] store [0:10];
    logic [5:0]   i;
    logic [31:0]  last_w;
    logic [31:0]  sub_word_q;
    logic         keys_valid_q;
    logic [127:0] rk_out_q;
    logic         rk_out_valid_q;

    logic [3:0]  rnd, prev_rnd;
    logic [1:0]  slot, slot_pos;
    logic [31:0] temp, w_new;

    function automatic logic [7:0] rcon(input logic [3:0] r);
        logic [7:0] c;
        c = 8'h00;
        case (r)
            4'd1:  c = 8'h01;
            4'd2:  c = 8'h02;
            4'd3:  c = 8'h04;
            4'd4:  c = 8'h08;
            4'd5:  c = 8'h10;
            4'd6:  c = 8'h20;
            4'd7:  c = 8'h40;
            4'd8:  c = 8'h80;
            4'd9:  c = 8'h1b;
            4'd10: c = 8'h36;
            default: c = 8'h00;
        endcase
        return c;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        step      = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (bus.start) begin
                    load      = 1'b1;
                    state_nxt = EXPAND;
                end
            end
            EXPAND: begin
                step = 1'b1;
                if (i == 6'd43) state_nxt = DONE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign rnd      = i[5:2];
    assign slot     = i[1:0];
    assign prev_rnd = rnd - 4'd1;
    assign slot_pos = 2'd3 - slot;

    always_comb begin
        temp = last_w;
        if (slot == 2'd0) temp = bus.sub_word_i ^ {rcon(rnd), 24'h0};
        w_new = store[prev_rnd][slot_pos] ^ temp;
    end

    // sub_word_o is registered one word ahead so SubWord sees RotWord(w[i-1]) in the i%4==0 cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r <= 10; r++) store[r] <= '0;
            i            <= '0;
            last_w       <= '0;
            sub_word_q   <= '0;
            keys_valid_q <= 1'b0;
        end else if (load) begin
            store[0]     <= bus.key_in;
            i            <= 6'd4;
            last_w       <= bus.key_in[31:0];
            sub_word_q   <= {bus.key_in[23:0], bus.key_in[31:24]};
            keys_valid_q <= 1'b0;
        end else if (step) begin
            store[rnd][slot_pos] <= w_new;
            i                    <= i + 6'd1;
            last_w               <= w_new;
            if (slot == 2'd3 && i != 6'd43) sub_word_q <= {w_new[23:0], w_new[31:24]};
        end else if (state == DONE) begin
            keys_valid_q <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rk_out_q       <= '0;
            rk_out_valid_q <= 1'b0;
        end else begin
            rk_out_valid_q <= bus.rk_rd;
            if (bus.rk_rd) rk_out_q <= (bus.rk_idx <= 4'd10) ? store[bus.rk_idx] : '0;
        end
    end

    assign bus.sub_word_o   = sub_word_q;
    assign bus.busy         = (state == EXPAND);
    assign bus.keys_valid   = keys_valid_q;
    assign bus.rk_out       = rk_out_q;
    assign bus.rk_out_valid = rk_out_valid_q;
endmodule

// File: tb/tb_aes_key_expand_ctrl.sv
// Bench for aes_key_expand_ctrl: plays the SubWord unit and the round-key consumer.
module tb_aes_key_expand_ctrl;
    logic clk;
    logic rst_n;

    aes_key_expand_ctrl_if #(.RK_W(128)) bus ();

    aes_key_expand_ctrl #(.NR(10), .RK_W(128)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [0:255][7:0] sbox_tbl = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [31:0] sub_word(input logic [31:0] x);
        return {sbox_tbl[x[31:24]], sbox_tbl[x[23:16]], sbox_tbl[x[15:8]], sbox_tbl[x[7:0]]};
    endfunction

    assign bus.sub_word_i = sub_word(bus.sub_word_o);

    // Straight-line FIPS-197 key expansion used as the reference schedule.
    function automatic logic [127:0] model_rk(input logic [127:0] key, input int r);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        for (int k = 0; k < 4; k++) w[k] = key[127-32*k -: 32];
        rc = 8'h01;
        for (int k = 4; k < 44; k++) begin
            t = w[k-1];
            if (k % 4 == 0) begin
                t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
            end
            w[k] = w[k-4] ^ t;
        end
        return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endfunction

    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] ZERO_KEY = 128'h0;

    typedef struct {
        logic [3:0]   idx;
        logic         rd;
        logic         exp_vld;
        logic [127:0] exp_out;
    } rd_vec_t;

    rd_vec_t fips_tbl [8];
    rd_vec_t zero_tbl [6];

    int nvec = 0;
    int nerr = 0;

    task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h, want %h", nm, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [127:0] key);
        bus.start  = 1'b1;
        bus.key_in = key;
        tick();
        bus.start  = 1'b0;
    endtask

    // Counts edges from the accepted start until keys_valid; optionally pulses start mid-run.
    task automatic run_to_valid(input int restart_at, input logic [127:0] rkey,
                                output int lat, output int busy_cnt);
        lat      = 0;
        busy_cnt = bus.busy ? 1 : 0;
        while (!bus.keys_valid && lat < 100) begin
            if (lat == restart_at) begin
                bus.start  = 1'b1;
                bus.key_in = rkey;
            end
            tick();
            bus.start = 1'b0;
            lat++;
            if (bus.busy) busy_cnt++;
        end
    endtask

    task automatic rd_key(input logic [3:0] idx);
        bus.rk_idx = idx;
        bus.rk_rd  = 1'b1;
        tick();
        bus.rk_rd  = 1'b0;
    endtask

    task automatic sweep(input logic [127:0] key, input string nm);
        for (int r = 0; r <= 10; r++) begin
            rd_key(4'(r));
            chk($sformatf("%s_rk%0d", nm, r), bus.rk_out, model_rk(key, r));
        end
    endtask

    task automatic apply_tbl(input rd_vec_t v, input string nm);
        bus.rk_idx = v.idx;
        bus.rk_rd  = v.rd;
        tick();
        bus.rk_rd  = 1'b0;
        chk({nm, "_vld"}, {127'b0, bus.rk_out_valid}, {127'b0, v.exp_vld});
        chk({nm, "_out"}, bus.rk_out, v.exp_out);
    endtask

    int lat, bcnt;

    initial begin
        fips_tbl[0] = '{4'd0,  1'b1, 1'b1, FIPS_KEY};
        fips_tbl[1] = '{4'd1,  1'b1, 1'b1, 128'ha0fafe1788542cb123a339392a6c7605};
        fips_tbl[2] = '{4'd2,  1'b1, 1'b1, 128'hf2c295f27a96b9435935807a7359f67f};
        fips_tbl[3] = '{4'd10, 1'b1, 1'b1, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
        fips_tbl[4] = '{4'd12, 1'b1, 1'b1, 128'h0};
        fips_tbl[5] = '{4'd3,  1'b0, 1'b0, 128'h0};
        fips_tbl[6] = '{4'd1,  1'b1, 1'b1, 128'ha0fafe1788542cb123a339392a6c7605};
        fips_tbl[7] = '{4'd5,  1'b0, 1'b0, 128'ha0fafe1788542cb123a339392a6c7605};

        zero_tbl[0] = '{4'd0,  1'b1, 1'b1, ZERO_KEY};
        zero_tbl[1] = '{4'd1,  1'b1, 1'b1, 128'h62636363626363636263636362636363};
        zero_tbl[2] = '{4'd10, 1'b1, 1'b1, 128'hb4ef5bcb3e92e21123e951cf6f8f188e};
        zero_tbl[3] = '{4'd7,  1'b0, 1'b0, 128'hb4ef5bcb3e92e21123e951cf6f8f188e};
        zero_tbl[4] = '{4'd15, 1'b1, 1'b1, 128'h0};
        zero_tbl[5] = '{4'd9,  1'b1, 1'b1, model_rk(ZERO_KEY, 9)};

        bus.start  = 1'b0;
        bus.key_in = '0;
        bus.rk_idx = '0;
        bus.rk_rd  = 1'b0;
        rst_n      = 1'b0;
        tick();
        tick();
        chk("rst_busy",   {127'b0, bus.busy}, 128'h0);
        chk("rst_kv",     {127'b0, bus.keys_valid}, 128'h0);
        chk("rst_rk_out", bus.rk_out, 128'h0);
        chk("rst_rk_vld", {127'b0, bus.rk_out_valid}, 128'h0);
        chk("rst_subw",   {96'b0, bus.sub_word_o}, 128'h0);
        rst_n = 1'b1;
        tick();

        // FIPS-197 key: timing, SubWord hand-off, table reads, full sweep.
        do_start(FIPS_KEY);
        chk("fips_busy0", {127'b0, bus.busy}, 128'h1);
        chk("fips_subw0", {96'b0, bus.sub_word_o}, {96'b0, 32'hcf4f3c09});
        run_to_valid(-1, '0, lat, bcnt);
        chk("fips_latency", 128'(lat), 128'd41);
        chk("fips_busy_cycles", 128'(bcnt), 128'd40);
        for (int k = 0; k < 8; k++) apply_tbl(fips_tbl[k], $sformatf("fips_v%0d", k));
        sweep(FIPS_KEY, "fips_model");

        // Re-key in DONE with the zero key.
        do_start(ZERO_KEY);
        chk("rekey_kv_drop", {127'b0, bus.keys_valid}, 128'h0);
        run_to_valid(-1, '0, lat, bcnt);
        chk("rekey_latency", 128'(lat), 128'd41);
        for (int k = 0; k < 6; k++) apply_tbl(zero_tbl[k], $sformatf("zero_v%0d", k));

        // A second start 10 cycles into EXPAND must be ignored.
        do_start(FIPS_KEY);
        run_to_valid(10, ZERO_KEY, lat, bcnt);
        chk("ignore_latency", 128'(lat), 128'd41);
        sweep(FIPS_KEY, "ignore");

        // Reset 20 cycles into EXPAND, then a fresh FIPS expansion.
        do_start(ZERO_KEY);
        for (int k = 0; k < 19; k++) tick();
        chk("mid_busy_pre", {127'b0, bus.busy}, 128'h1);
        bus.rk_idx = 4'd0;
        bus.rk_rd  = 1'b1;
        rst_n      = 1'b0;
        #1;
        chk("mid_rst_busy", {127'b0, bus.busy}, 128'h0);
        tick();
        chk("mid_rst_kv",  {127'b0, bus.keys_valid}, 128'h0);
        chk("mid_rst_vld", {127'b0, bus.rk_out_valid}, 128'h0);
        chk("mid_rst_out", bus.rk_out, 128'h0);
        bus.rk_rd = 1'b0;
        rst_n     = 1'b1;
        rd_key(4'd1);
        chk("mid_cleared_rk1", bus.rk_out, 128'h0);
        chk("mid_cleared_vld", {127'b0, bus.rk_out_valid}, 128'h1);
        for (int k = 0; k < 5; k++) tick();
        chk("mid_idle_kv", {127'b0, bus.keys_valid}, 128'h0);
        do_start(FIPS_KEY);
        run_to_valid(-1, '0, lat, bcnt);
        chk("post_rst_latency", 128'(lat), 128'd41);
        sweep(FIPS_KEY, "post_rst");

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
